forwarding_hazard_unit: RTL and testbench

Parametrised successor to the pipeline's combinational forwarding logic. It tracks the destination tags of in-flight instructions in its own EX, MEM and WB tag registers. From those it produces per-operand forwarding selects for the EX-stage instruction, with independent priority per operand. It also generates load-use and multi-cycle-multiply stalls and keeps a saturating stall-cycle counter. It sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers and drives the EX operand muxes and the PC/IF-ID write enables.

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/pipe_tag_reg.sv | 36 +++
 rtl/forwarding_hazard_unit.sv | 146 ++++++++++++++
 tb/tb_forwarding_hazard_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the forwarding / hazard-detection slice.
package hazard_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Per-stage tag flags; the register indices travel alongside as a packed payload
  // because their widths follow the instantiating module's parameters.
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic is_load;
  } tag_t;

  typedef enum logic [1:0] {
    NONE,
    LOAD_USE,
    MUL_BUSY,
    FLUSH
  } stall_cause_e;

  // A stage can only be a forwarding source when it holds a real writing instruction.
  function automatic logic tag_writes(tag_t t);
    return t.valid && t.reg_write;
  endfunction

endpackage

// File: rtl/pipe_tag_reg.sv
// One pipeline tag entry: bubble clears it, hold keeps it, load captures the new tag.
module pipe_tag_reg
  import hazard_pkg::*;
#(
  parameter int DATA_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              bubble,
  input  logic              hold,
  input  logic              load,
  input  tag_t              d_tag,
  input  logic [DATA_W-1:0] d_data,
  output tag_t              q_tag,
  output logic [DATA_W-1:0] q_data
);

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the pre-edge value of its neighbour, which is what makes the tags shift.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_tag  <= '0;
      q_data <= '0;
    end else if (bubble) begin
      q_tag  <= '0;
      q_data <= '0;
    end else if (hold) begin
      q_tag  <= q_tag;
      q_data <= q_data;
    end else if (load) begin
      q_tag  <= d_tag;
      q_data <= d_data;
    end
  end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Tracks in-flight destination tags, selects EX operand forwarding and raises
// load-use / multiply stalls with a saturating stall-cycle counter.
module forwarding_hazard_unit
  import hazard_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int REG_ADDR_W = 5,
  parameter int MUL_LAT    = 3
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
  input  logic [NUM_SRC-1:0]            id_rs_used,
  input  logic [REG_ADDR_W-1:0]         id_rd,
  input  logic                          id_reg_write,
  input  logic                          id_is_load,
  input  logic                          id_is_mul,
  input  logic                          flush,
  output logic                          stall,
  output logic                          ex_hold,
  output logic [2*NUM_SRC-1:0]          fwd_sel,
  output logic [31:0]                   stall_cycles
);

  localparam int RS_W  = NUM_SRC * REG_ADDR_W;
  localparam int EX_W  = NUM_SRC + RS_W + REG_ADDR_W;
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_RELOAD = CNT_W'(MUL_LAT - 1);

  tag_t                  id_tag, ex_tag, mem_tag, wb_tag;
  logic [EX_W-1:0]       id_data, ex_data;
  logic [REG_ADDR_W-1:0] ex_rd, mem_rd, wb_rd;
  logic [RS_W-1:0]       ex_rs;
  logic [NUM_SRC-1:0]    ex_rs_used;
  logic [CNT_W-1:0]      mul_cnt;
  logic                  ex_match, mem_match, wb_match;
  logic                  id_dep_hit, load_use, mul_busy;
  stall_cause_e          cause;

  assign id_tag  = '{valid: id_valid, reg_write: id_reg_write, is_load: id_is_load};
  assign id_data = {id_rs_used, id_rs, id_rd};

  assign ex_rd      = ex_data[REG_ADDR_W-1:0];
  assign ex_rs      = ex_data[REG_ADDR_W +: RS_W];
  assign ex_rs_used = ex_data[EX_W-1 -: NUM_SRC];

  assign ex_match  = tag_writes(ex_tag)  && (ex_rd  != '0);
  assign mem_match = tag_writes(mem_tag) && (mem_rd != '0);
  assign wb_match  = tag_writes(wb_tag)  && (wb_rd  != '0);
  assign mul_busy  = (mul_cnt != '0);

  // NOTE: every always_comb output gets a default before any conditional
  // assignment so no path can leave it unassigned and infer a latch.
  always_comb begin
    fwd_sel    = '0;
    id_dep_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ex_rs_used[i]) begin
        if (mem_match && (mem_rd == ex_rs[i*REG_ADDR_W +: REG_ADDR_W])) begin
          fwd_sel[2*i +: 2] = FWD_EXMEM;
        end else if (wb_match && (wb_rd == ex_rs[i*REG_ADDR_W +: REG_ADDR_W])) begin
          fwd_sel[2*i +: 2] = FWD_MEMWB;
        end else begin
          fwd_sel[2*i +: 2] = FWD_RF;
        end
      end
      if (id_valid && id_rs_used[i] && (id_rs[i*REG_ADDR_W +: REG_ADDR_W] == ex_rd)) begin
        id_dep_hit = 1'b1;
      end
    end
  end

  assign load_use = ex_match && ex_tag.is_load && id_dep_hit;

  // One priority decision drives the outputs, the tag shift and the multiply counter.
  always_comb begin
    cause = NONE;
    if (flush)         cause = FLUSH;
    else if (mul_busy) cause = MUL_BUSY;
    else if (load_use) cause = LOAD_USE;
  end

  assign stall   = (cause == MUL_BUSY) || (cause == LOAD_USE);
  assign ex_hold = (cause == MUL_BUSY);

  pipe_tag_reg #(.DATA_W(EX_W)) u_ex_tag (
    .clk     (clk),
    .reset_n (reset_n),
    .bubble  ((cause == FLUSH) || (cause == LOAD_USE)),
    .hold    (cause == MUL_BUSY),
    .load    (1'b1),
    .d_tag   (id_tag),
    .d_data  (id_data),
    .q_tag   (ex_tag),
    .q_data  (ex_data)
  );

  // While a multiply sits in EX nothing leaves it, so MEM receives a bubble.
  pipe_tag_reg #(.DATA_W(REG_ADDR_W)) u_mem_tag (
    .clk     (clk),
    .reset_n (reset_n),
    .bubble  (cause == MUL_BUSY),
    .hold    (1'b0),
    .load    (1'b1),
    .d_tag   (ex_tag),
    .d_data  (ex_rd),
    .q_tag   (mem_tag),
    .q_data  (mem_rd)
  );

  pipe_tag_reg #(.DATA_W(REG_ADDR_W)) u_wb_tag (
    .clk     (clk),
    .reset_n (reset_n),
    .bubble  (1'b0),
    .hold    (1'b0),
    .load    (1'b1),
    .d_tag   (mem_tag),
    .d_data  (mem_rd),
    .q_tag   (wb_tag),
    .q_data  (wb_rd)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mul_cnt <= '0;
    end else begin
      unique case (cause)
        FLUSH:    mul_cnt <= '0;
        MUL_BUSY: mul_cnt <= mul_cnt - 1'b1;
        LOAD_USE: mul_cnt <= mul_cnt;
        NONE:     if (id_valid && id_is_mul) mul_cnt <= MUL_RELOAD;
        default:  mul_cnt <= mul_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench for forwarding_hazard_unit: forwarding, load-use, multiply,
// x0/unused sources, flush priority and asynchronous reset mid-stall.
module tb_forwarding_hazard_unit;

  logic        clk;
  logic        reset_n;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic        id_is_load;
  logic        id_is_mul;
  logic        flush;
  logic        stall;
  logic        ex_hold;
  logic [3:0]  fwd_sel;
  logic [31:0] stall_cycles;

  int tests_run = 0;
  int tests_failed = 0;

  forwarding_hazard_unit #(
    .NUM_SRC    (2),
    .REG_ADDR_W (5),
    .MUL_LAT    (3)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rs_used   (id_rs_used),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_is_load   (id_is_load),
    .id_is_mul    (id_is_mul),
    .flush        (flush),
    .stall        (stall),
    .ex_hold      (ex_hold),
    .fwd_sel      (fwd_sel),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present an ID-stage instruction, then let the combinational outputs settle.
  task automatic drive(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [1:0] used, input logic [4:0] rd, input logic wr,
                       input logic ld, input logic mul);
    id_valid     = v;
    id_rs        = {rs1, rs0};
    id_rs_used   = used;
    id_rd        = rd;
    id_reg_write = wr;
    id_is_load   = ld;
    id_is_mul    = mul;
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  initial begin
    reset_n = 1'b0;
    flush   = 1'b0;
    nop();
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_ex_hold", {31'd0, ex_hold}, 32'd0);
    check("reset_fwd_sel", {28'd0, fwd_sel}, 32'd0);
    check("reset_stall_cycles", stall_cycles, 32'd0);
    #10 reset_n = 1'b1;

    // Independent forwarding: add x5; add x6; add x7,x5,x6
    drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd5, 5'd6, 2'b11, 5'd7, 1'b1, 1'b0, 1'b0);
    check("fwd_issue_no_stall", {31'd0, stall}, 32'd0);
    tick();
    nop();
    check("fwd_independent", {28'd0, fwd_sel}, 32'h6);
    check("fwd_no_stall", {31'd0, stall}, 32'd0);
    drain();

    // Load-use: lw x3; add x4,x3,x1
    drive(1'b1, 5'd2, 5'd0, 2'b01, 5'd3, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 5'd3, 5'd1, 2'b11, 5'd4, 1'b1, 1'b0, 1'b0);
    check("lu_stall", {31'd0, stall}, 32'd1);
    check("lu_no_ex_hold", {31'd0, ex_hold}, 32'd0);
    tick();
    check("lu_stall_released", {31'd0, stall}, 32'd0);
    check("lu_count_after_bubble", stall_cycles, 32'd1);
    tick();
    nop();
    check("lu_fwd_from_wb", {28'd0, fwd_sel}, 32'h2);
    check("lu_count", stall_cycles, 32'd1);
    drain();

    // Multiply: mul x8; add x9,x8,x0
    drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd8, 1'b1, 1'b0, 1'b1);
    check("mul_issue_no_stall", {31'd0, stall}, 32'd0);
    tick();
    drive(1'b1, 5'd8, 5'd0, 2'b11, 5'd9, 1'b1, 1'b0, 1'b0);
    check("mul_busy1_stall", {31'd0, stall}, 32'd1);
    check("mul_busy1_hold", {31'd0, ex_hold}, 32'd1);
    tick();
    check("mul_busy2_stall", {31'd0, stall}, 32'd1);
    check("mul_busy2_hold", {31'd0, ex_hold}, 32'd1);
    tick();
    check("mul_done_stall", {31'd0, stall}, 32'd0);
    check("mul_done_hold", {31'd0, ex_hold}, 32'd0);
    tick();
    nop();
    check("mul_fwd_from_mem", {28'd0, fwd_sel}, 32'h1);
    check("mul_count", stall_cycles, 32'd3);
    drain();

    // x0 producer: lw x0; add using x0
    drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd0, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 5'd0, 5'd0, 2'b11, 5'd20, 1'b1, 1'b0, 1'b0);
    check("x0_no_stall", {31'd0, stall}, 32'd0);
    tick();
    nop();
    check("x0_no_fwd", {28'd0, fwd_sel}, 32'd0);
    drain();

    // Unused sources: lw x11; consumer names x11 but reads neither source
    drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd11, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 5'd11, 5'd11, 2'b00, 5'd21, 1'b1, 1'b0, 1'b0);
    check("unused_no_stall", {31'd0, stall}, 32'd0);
    tick();
    nop();
    check("unused_no_fwd", {28'd0, fwd_sel}, 32'd0);
    drain();

    // id_valid=0 never stalls even when the indices match a load in EX
    drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd10, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b0, 5'd10, 5'd10, 2'b11, 5'd22, 1'b1, 1'b0, 1'b0);
    check("invalid_id_no_stall", {31'd0, stall}, 32'd0);
    drain();

    // Flush wins over load-use and the next EX tag is a bubble
    drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd12, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 5'd12, 5'd0, 2'b01, 5'd13, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    check("flush_beats_load_use", {31'd0, stall}, 32'd0);
    tick();
    flush = 1'b0;
    nop();
    check("flush_ex_bubble_fwd", {28'd0, fwd_sel}, 32'd0);
    check("flush_count_unchanged", stall_cycles, 32'd3);
    drain();

    // Asynchronous reset in the middle of multiply busy
    drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd14, 1'b1, 1'b0, 1'b1); tick();
    drive(1'b1, 5'd14, 5'd0, 2'b01, 5'd15, 1'b1, 1'b0, 1'b0);
    check("pre_reset_stall", {31'd0, stall}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_ex_hold", {31'd0, ex_hold}, 32'd0);
    check("rst_fwd_sel", {28'd0, fwd_sel}, 32'd0);
    check("rst_stall_cycles", stall_cycles, 32'd0);
    tick();
    reset_n = 1'b1;
    drive(1'b1, 5'd14, 5'd0, 2'b01, 5'd16, 1'b1, 1'b0, 1'b0);
    check("post_rst_no_stall", {31'd0, stall}, 32'd0);
    tick();
    nop();
    check("post_rst_no_fwd", {28'd0, fwd_sel}, 32'd0);
    check("post_rst_count", stall_cycles, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
